// File: rtl/ppu_result_collector.sv
// In-order pairing buffer: snoops PPU issues and results and emits complete
// {seq, in1, op, in2, out} records on a valid/ready stream.
module ppu_result_collector #(
    parameter int WORD    = 32,
    parameter int OP_SIZE = 3,
    parameter int DEPTH   = 8,
    parameter int SEQ_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ppu_valid_in,
    input  logic [WORD-1:0]        ppu_in1,
    input  logic [WORD-1:0]        ppu_in2,
    input  logic [OP_SIZE-1:0]     ppu_op,
    input  logic                   ppu_valid_o,
    input  logic [WORD-1:0]        ppu_out,
    output logic                   ppu_ready_o,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [SEQ_W-1:0]       rec_seq,
    output logic [WORD-1:0]        rec_in1,
    output logic [WORD-1:0]        rec_in2,
    output logic [OP_SIZE-1:0]     rec_op,
    output logic [WORD-1:0]        rec_out,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_overflow,
    output logic                   err_orphan
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, res_ptr_q, res_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [SEQ_W-1:0]   seq_mem_q [DEPTH];
    logic [SEQ_W-1:0]   seq_mem_d [DEPTH];
    logic [WORD-1:0]    in1_mem_q [DEPTH];
    logic [WORD-1:0]    in1_mem_d [DEPTH];
    logic [WORD-1:0]    in2_mem_q [DEPTH];
    logic [WORD-1:0]    in2_mem_d [DEPTH];
    logic [OP_SIZE-1:0] op_mem_q  [DEPTH];
    logic [OP_SIZE-1:0] op_mem_d  [DEPTH];
    logic [WORD-1:0]    out_mem_q [DEPTH];
    logic [WORD-1:0]    out_mem_d [DEPTH];
    logic [DEPTH-1:0]   done_q, done_d;
    logic               err_overflow_q, err_overflow_d, err_orphan_q, err_orphan_d;

    logic [PW-1:0] count;
    logic [AW-1:0] wr_idx, res_idx, rd_idx;
    logic          full, issue, result, pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == PW'(DEPTH));
    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign res_idx = res_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];

    assign issue  = ppu_valid_in && !full;
    // A result only pairs with an issue captured on an earlier edge.
    assign result = ppu_valid_o && (res_ptr_q != wr_ptr_q);
    assign pop    = rec_valid && rec_ready;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        res_ptr_d      = res_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        seq_cnt_d      = seq_cnt_q;
        seq_mem_d      = seq_mem_q;
        in1_mem_d      = in1_mem_q;
        in2_mem_d      = in2_mem_q;
        op_mem_d       = op_mem_q;
        out_mem_d      = out_mem_q;
        done_d         = done_q;
        err_overflow_d = err_overflow_q || (ppu_valid_in && full);
        err_orphan_d   = err_orphan_q || (ppu_valid_o && !result);

        if (issue) begin
            seq_mem_d[wr_idx] = seq_cnt_q;
            in1_mem_d[wr_idx] = ppu_in1;
            in2_mem_d[wr_idx] = ppu_in2;
            op_mem_d[wr_idx]  = ppu_op;
            done_d[wr_idx]    = 1'b0;
            wr_ptr_d          = wr_ptr_q + PW'(1);
            seq_cnt_d         = seq_cnt_q + SEQ_W'(1);
        end
        if (result) begin
            out_mem_d[res_idx] = ppu_out;
            done_d[res_idx]    = 1'b1;
            res_ptr_d          = res_ptr_q + PW'(1);
        end
        // Index collisions between the three writers are impossible: they
        // would require the buffer to be both empty and full.
        if (pop) begin
            done_d[rd_idx] = 1'b0;
            rd_ptr_d       = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            res_ptr_q      <= '0;
            rd_ptr_q       <= '0;
            seq_cnt_q      <= '0;
            done_q         <= '0;
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                seq_mem_q[i] <= '0;
                in1_mem_q[i] <= '0;
                in2_mem_q[i] <= '0;
                op_mem_q[i]  <= '0;
                out_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            res_ptr_q      <= res_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            seq_cnt_q      <= seq_cnt_d;
            done_q         <= done_d;
            err_overflow_q <= err_overflow_d;
            err_orphan_q   <= err_orphan_d;
            seq_mem_q      <= seq_mem_d;
            in1_mem_q      <= in1_mem_d;
            in2_mem_q      <= in2_mem_d;
            op_mem_q       <= op_mem_d;
            out_mem_q      <= out_mem_d;
        end
    end

    assign ppu_ready_o  = !full;
    assign outstanding  = count;
    assign rec_valid    = done_q[rd_idx] && ((rd_ptr_q != res_ptr_q) || (count != '0));
    assign rec_seq      = seq_mem_q[rd_idx];
    assign rec_in1      = in1_mem_q[rd_idx];
    assign rec_in2      = in2_mem_q[rd_idx];
    assign rec_op       = op_mem_q[rd_idx];
    assign rec_out      = out_mem_q[rd_idx];
    assign err_overflow = err_overflow_q;
    assign err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_ppu_result_collector.sv
// Bench for ppu_result_collector: directed scenarios plus random traffic
// checked against a queue-based record model.
module tb_ppu_result_collector;
    localparam int WORD = 32, OP_SIZE = 3, DEPTH = 8, SEQ_W = 16;
    localparam logic [2:0] OP_SUB = 3'd1, OP_DIV = 3'd3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ppu_valid_in = 0, ppu_valid_o = 0, rec_ready = 0;
    logic [WORD-1:0] ppu_in1 = '0, ppu_in2 = '0, ppu_out = '0;
    logic [OP_SIZE-1:0] ppu_op = '0;
    logic ppu_ready_o, rec_valid, err_overflow, err_orphan;
    logic [SEQ_W-1:0] rec_seq;
    logic [WORD-1:0] rec_in1, rec_in2, rec_out;
    logic [OP_SIZE-1:0] rec_op;
    logic [$clog2(DEPTH):0] outstanding;

    ppu_result_collector #(.WORD(WORD), .OP_SIZE(OP_SIZE), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst_n(rst_n), .ppu_valid_in(ppu_valid_in), .ppu_in1(ppu_in1),
        .ppu_in2(ppu_in2), .ppu_op(ppu_op), .ppu_valid_o(ppu_valid_o), .ppu_out(ppu_out),
        .ppu_ready_o(ppu_ready_o), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_seq(rec_seq), .rec_in1(rec_in1), .rec_in2(rec_in2), .rec_op(rec_op),
        .rec_out(rec_out), .outstanding(outstanding), .err_overflow(err_overflow),
        .err_orphan(err_orphan));

    always #5 clk = ~clk;

    typedef struct {
        logic [SEQ_W-1:0]   seq;
        logic [WORD-1:0]    in1;
        logic [OP_SIZE-1:0] op;
        logic [WORD-1:0]    in2;
        logic [WORD-1:0]    out;
        bit                 done;
    } rec_t;

    rec_t mq[$];
    int m_ndone;
    logic [SEQ_W-1:0] m_seq;
    bit m_ovf, m_orph;
    int checks = 0, failures = 0;

    function automatic void model_clear();
        mq.delete();
        m_ndone = 0;
        m_seq = '0;
        m_ovf = 0;
        m_orph = 0;
    endfunction

    // Advance model by one edge using the currently driven inputs, then clock.
    task automatic tick();
        bit pv, full_pre;
        rec_t r;
        pv = (mq.size() > 0) && mq[0].done;
        full_pre = (mq.size() == DEPTH);
        if (ppu_valid_o) begin
            if (m_ndone < mq.size()) begin
                r = mq[m_ndone];
                r.out = ppu_out;
                r.done = 1;
                mq[m_ndone] = r;
                m_ndone++;
            end else m_orph = 1;
        end
        if (pv && rec_ready) begin
            void'(mq.pop_front());
            m_ndone--;
        end
        if (ppu_valid_in) begin
            if (!full_pre) begin
                r.seq = m_seq; r.in1 = ppu_in1; r.op = ppu_op; r.in2 = ppu_in2;
                r.out = '0; r.done = 0;
                mq.push_back(r);
                m_seq = m_seq + 1'b1;
            end else m_ovf = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ppu_valid_in = 0; ppu_valid_o = 0; rec_ready = 0;
        ppu_in1 = '0; ppu_in2 = '0; ppu_op = '0; ppu_out = '0;
        rst_n = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outstanding !== '0 || ppu_ready_o !== 1'b1 || rec_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: outstanding=%0d ready=%b rec_valid=%b, want 0 1 0",
                     outstanding, ppu_ready_o, rec_valid);
        end
        checks++;
        if (rec_seq !== '0 || rec_in1 !== '0 || rec_in2 !== '0 || rec_op !== '0 || rec_out !== '0) begin
            failures++;
            $display("FAIL reset_data: seq=%0d in1=%h in2=%h op=%0d out=%h, want all 0",
                     rec_seq, rec_in1, rec_in2, rec_op, rec_out);
        end
        checks++;
        if (err_overflow !== 1'b0 || err_orphan !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: ovf=%b orph=%b, want 0 0", err_overflow, err_orphan);
        end
    endtask

    task automatic test_single_sub();
        do_reset();
        ppu_valid_in = 1; ppu_in1 = 120; ppu_in2 = 0; ppu_op = OP_SUB;
        tick();
        ppu_valid_in = 0;
        tick();
        tick();
        checks++;
        if (rec_valid !== 1'b0 || outstanding !== 1) begin
            failures++;
            $display("FAIL sub_pending: rec_valid=%b outstanding=%0d, want 0 1", rec_valid, outstanding);
        end
        ppu_valid_o = 1; ppu_out = 32'h78;
        tick();
        ppu_valid_o = 0;
        checks++;
        if (rec_valid !== 1'b1 || rec_seq !== 0 || rec_in1 !== 120 || rec_op !== OP_SUB ||
            rec_in2 !== 0 || rec_out !== 32'h78) begin
            failures++;
            $display("FAIL sub_record: v=%b seq=%0d in1=%0d op=%0d in2=%0d out=%h, want 1 0 120 %0d 0 78",
                     rec_valid, rec_seq, rec_in1, rec_op, rec_in2, rec_out, OP_SUB);
        end
        rec_ready = 1;
        tick();
        rec_ready = 0;
        checks++;
        if (rec_valid !== 1'b0 || outstanding !== 0) begin
            failures++;
            $display("FAIL sub_pop: rec_valid=%b outstanding=%0d, want 0 0", rec_valid, outstanding);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ppu_valid_in = 1; ppu_in1 = 120; ppu_in2 = 0; ppu_op = OP_SUB;
        tick();
        ppu_in1 = 15; ppu_in2 = 15; ppu_op = OP_DIV;
        tick();
        ppu_valid_in = 0;
        ppu_valid_o = 1; ppu_out = 32'h78; rec_ready = 1;
        tick();
        checks++;
        if (rec_valid !== 1'b1 || rec_seq !== 0 || rec_out !== 32'h78 || rec_in1 !== 120) begin
            failures++;
            $display("FAIL b2b_first: v=%b seq=%0d in1=%0d out=%h, want 1 0 120 78",
                     rec_valid, rec_seq, rec_in1, rec_out);
        end
        ppu_out = 32'h4000;
        tick();
        ppu_valid_o = 0;
        checks++;
        if (rec_valid !== 1'b1 || rec_seq !== 1 || rec_in1 !== 15 || rec_in2 !== 15 ||
            rec_op !== OP_DIV || rec_out !== 32'h4000) begin
            failures++;
            $display("FAIL b2b_second: v=%b seq=%0d in1=%0d in2=%0d op=%0d out=%h, want 1 1 15 15 %0d 4000",
                     rec_valid, rec_seq, rec_in1, rec_in2, rec_op, rec_out, OP_DIV);
        end
        tick();
        rec_ready = 0;
        checks++;
        if (rec_valid !== 1'b0 || outstanding !== 0) begin
            failures++;
            $display("FAIL b2b_drain: rec_valid=%b outstanding=%0d, want 0 0", rec_valid, outstanding);
        end
    endtask

    task automatic test_backpressure();
        logic [WORD-1:0] outs [DEPTH];
        do_reset();
        rec_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ppu_valid_in = 1; ppu_in1 = $urandom; ppu_in2 = $urandom; ppu_op = 3'($urandom);
            tick();
        end
        ppu_valid_in = 0;
        checks++;
        if (ppu_ready_o !== 1'b0 || outstanding !== DEPTH) begin
            failures++;
            $display("FAIL bp_full: ready=%b outstanding=%0d, want 0 %0d", ppu_ready_o, outstanding, DEPTH);
        end
        ppu_valid_in = 1; ppu_in1 = 32'hdead;
        tick();
        ppu_valid_in = 0;
        checks++;
        if (err_overflow !== 1'b1 || outstanding !== DEPTH) begin
            failures++;
            $display("FAIL bp_overflow: ovf=%b outstanding=%0d, want 1 %0d", err_overflow, outstanding, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            outs[i] = $urandom;
            ppu_valid_o = 1; ppu_out = outs[i];
            tick();
        end
        ppu_valid_o = 0;
        rec_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (rec_valid !== 1'b1 || rec_seq !== SEQ_W'(i) || rec_out !== outs[i]) begin
                failures++;
                $display("FAIL bp_drain[%0d]: v=%b seq=%0d out=%h, want 1 %0d %h",
                         i, rec_valid, rec_seq, rec_out, i, outs[i]);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (ppu_ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_ready_rise: ready=%b, want 1", ppu_ready_o);
                end
            end
        end
        rec_ready = 0;
        checks++;
        if (rec_valid !== 1'b0 || outstanding !== 0 || err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_empty: v=%b outstanding=%0d ovf=%b, want 0 0 1", rec_valid, outstanding, err_overflow);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        ppu_valid_o = 1; ppu_out = 32'h1234;
        tick();
        ppu_valid_o = 0;
        checks++;
        if (err_orphan !== 1'b1 || rec_valid !== 1'b0 || outstanding !== 0) begin
            failures++;
            $display("FAIL orphan: orph=%b v=%b outstanding=%0d, want 1 0 0", err_orphan, rec_valid, outstanding);
        end
        ppu_valid_in = 1; ppu_valid_o = 1;
        tick();
        ppu_valid_in = 0; ppu_valid_o = 0;
        checks++;
        if (rec_valid !== 1'b0 || outstanding !== 1) begin
            failures++;
            $display("FAIL orphan_same_cycle: v=%b outstanding=%0d, want 0 1", rec_valid, outstanding);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ppu_valid_in = 1; ppu_in1 = i; ppu_in2 = $urandom; ppu_op = 3'($urandom);
            tick();
            ppu_valid_in = 0;
            ppu_valid_o = 1; ppu_out = 32'(i * 3);
            tick();
            ppu_valid_o = 0;
            checks++;
            if (rec_valid !== 1'b1 || rec_seq !== SEQ_W'(i) || rec_in1 !== 32'(i) || rec_out !== 32'(i * 3)) begin
                failures++;
                $display("FAIL wrap[%0d]: v=%b seq=%0d in1=%0d out=%0d, want 1 %0d %0d %0d",
                         i, rec_valid, rec_seq, rec_in1, rec_out, i, i, i * 3);
            end
            rec_ready = 1;
            tick();
            rec_ready = 0;
        end
        checks++;
        if (err_overflow !== 1'b0 || err_orphan !== 1'b0 || outstanding !== 0) begin
            failures++;
            $display("FAIL wrap_flags: ovf=%b orph=%b outstanding=%0d, want 0 0 0",
                     err_overflow, err_orphan, outstanding);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ppu_valid_in = 1; ppu_in1 = 100 + i;
            ppu_valid_o = (i == 1);
            tick();
        end
        ppu_valid_in = 0; ppu_valid_o = 0;
        rst_n = 0;
        #1;
        checks++;
        if (outstanding !== 0 || ppu_ready_o !== 1'b1 || rec_valid !== 1'b0 || rec_seq !== 0 ||
            rec_in1 !== 0 || rec_out !== 0) begin
            failures++;
            $display("FAIL reset_mid_async: outstanding=%0d ready=%b v=%b seq=%0d in1=%0d out=%0d, want 0 1 0 0 0 0",
                     outstanding, ppu_ready_o, rec_valid, rec_seq, rec_in1, rec_out);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
        ppu_valid_in = 1; ppu_in1 = 7; ppu_op = OP_SUB;
        tick();
        ppu_valid_in = 0; ppu_valid_o = 1; ppu_out = 32'h55;
        tick();
        ppu_valid_o = 0;
        checks++;
        if (rec_valid !== 1'b1 || rec_seq !== 0 || rec_in1 !== 7 || rec_out !== 32'h55) begin
            failures++;
            $display("FAIL reset_mid_seq: v=%b seq=%0d in1=%0d out=%h, want 1 0 7 55",
                     rec_valid, rec_seq, rec_in1, rec_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            ppu_valid_in = ($urandom_range(0, 99) < 45);
            ppu_in1 = $urandom; ppu_in2 = $urandom; ppu_op = 3'($urandom);
            ppu_valid_o = (m_ndone < mq.size()) ? ($urandom_range(0, 99) < 50)
                                                : ($urandom_range(0, 99) < 2);
            ppu_out = $urandom;
            rec_ready = ($urandom_range(0, 99) < 55);
            tick();
            checks++;
            if (outstanding !== mq.size() || ppu_ready_o !== (mq.size() != DEPTH) ||
                rec_valid !== ((mq.size() > 0) && mq[0].done)) begin
                failures++;
                $display("FAIL rand_ctrl@%0d: outstanding=%0d ready=%b v=%b, want %0d %b %b", c,
                         outstanding, ppu_ready_o, rec_valid, mq.size(), mq.size() != DEPTH,
                         (mq.size() > 0) && mq[0].done);
            end
            checks++;
            if (err_overflow !== m_ovf || err_orphan !== m_orph) begin
                failures++;
                $display("FAIL rand_err@%0d: ovf=%b orph=%b, want %b %b", c, err_overflow, err_orphan, m_ovf, m_orph);
            end
            if (mq.size() > 0 && mq[0].done) begin
                checks++;
                if (rec_seq !== mq[0].seq || rec_in1 !== mq[0].in1 || rec_in2 !== mq[0].in2 ||
                    rec_op !== mq[0].op || rec_out !== mq[0].out) begin
                    failures++;
                    $display("FAIL rand_rec@%0d: seq=%0d in1=%h in2=%h op=%0d out=%h, want %0d %h %h %0d %h", c,
                             rec_seq, rec_in1, rec_in2, rec_op, rec_out,
                             mq[0].seq, mq[0].in1, mq[0].in2, mq[0].op, mq[0].out);
                end
            end
        end
        ppu_valid_in = 0; ppu_valid_o = 0; rec_ready = 0;
    endtask

    initial begin
        model_clear();
        #2;
        test_reset();
        test_single_sub();
        test_back_to_back();
        test_backpressure();
        test_orphan();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ppu_result_collector.md
# ppu_result_collector

In-order request/result pairing buffer on the issue and result ports of the pipelined PPU (`ppu_top`). It snoops every accepted operation (`ppu_in1`, `ppu_op`, `ppu_in2`) and matches it to the corresponding `ppu_out` pulse. It then presents a complete record `{seq, in1, op, in2, out}` on a valid/ready stream. It is the hardware receiving end of the PPU command/result interface: a downstream checker, logger or DMA consumes results here, and `ppu_ready_o` throttles the issuer so no result is ever lost.

## Interface

- `WORD`, default 32: operand/result width.
- `OP_SIZE`, default 3: width of the `ppu_op` encoding.
- `DEPTH`, default 8: buffer entries; power of two, ≥2.
- `SEQ_W`, default 16: sequence counter width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ppu_valid_in` in 1: issue strobe seen by the PPU.
- `ppu_in1` in WORD: operand 1.
- `ppu_in2` in WORD: operand 2.
- `ppu_op` in OP_SIZE: operation code.
- `ppu_valid_o` in 1: PPU result strobe.
- `ppu_out` in WORD: PPU result.
- `ppu_ready_o` out 1: issuer may assert `ppu_valid_in` this cycle.
- `rec_valid` out 1: head record complete.
- `rec_ready` in 1: consumer accepts the head record.
- `rec_seq` out SEQ_W: record sequence number.
- `rec_in1`, `rec_in2` out WORD: record operands.
- `rec_op` out OP_SIZE: record operation code.
- `rec_out` out WORD: record result.
- `outstanding` out log2(DEPTH)+1: allocated entries.
- `err_overflow` out 1: sticky; an issue arrived while full.
- `err_orphan` out 1: sticky; a result arrived with no pending request.

## Operation

- Circular buffer of DEPTH entries. Each entry holds `{seq, in1, op, in2, out, done}`.
- Three pointers, each log2(DEPTH)+1 bits with a wrap bit: `wr_ptr` (allocate), `res_ptr` (next result), `rd_ptr` (head).
- `outstanding = wr_ptr - rd_ptr`. Full when the value equals DEPTH.
- `ppu_ready_o = !full`, derived from registered state only.
- Issue: when `ppu_valid_in` is high and the buffer is not full, the block writes `{seq_cnt, in1, op, in2}` at `wr_ptr` and clears `done`. It then increments `wr_ptr` and `seq_cnt`.
  - `seq_cnt` wraps from 2^SEQ_W−1 to 0.
- Issue while full: the operation is dropped and `err_overflow` is set to 1.
- Result: when `ppu_valid_o` is high and `res_ptr != wr_ptr` (value before this edge), the block writes `out` at `res_ptr`, sets `done`, and increments `res_ptr`.
- Result with `res_ptr == wr_ptr`: the result is dropped and `err_orphan` is set to 1. This applies even if an issue is accepted on the same edge; a result never pairs with a same-cycle issue.
- Results can never overflow, because every result slot is reserved at issue time.
- Output: `rec_valid = done[rd_ptr] && (rd_ptr != res_ptr || outstanding != 0)`. The `rec_*` fields come from the head entry.
- Pop: when `rec_valid && rec_ready`, the block clears `done[rd_ptr]` and increments `rd_ptr`.
- Issue, result and pop may all occur on one edge; each acts independently on its own pointer.
  - Pop plus issue while full is legal only if `ppu_ready_o` was high. Since `ppu_ready_o` is low when full, the issuer must wait one cycle.
- The error flags clear only on reset.
- `rec_*` data is stable while `rec_valid && !rec_ready`.

## Timing

- Reset (asynchronous, `rst_n` = 0):
  - All pointers, `seq_cnt`, all `done` bits and both error flags go to 0.
  - `rec_valid` = 0, `outstanding` = 0, `ppu_ready_o` = 1.
  - `rec_*` data = 0.
- Deassertion of `rst_n` is synchronised externally. The first active edge is the one after release.
- Reset mid-operation discards all pending entries with no record emitted. `seq` restarts at 0.
- Issue capture happens on the rising edge where `ppu_valid_in` is high. `outstanding` updates one cycle later.
- Result capture happens on the rising edge where `ppu_valid_o` is high. `rec_valid` rises in the following cycle if that entry is at the head.
  - Added latency from result to record is 1 cycle.
- Throughput is 1 record/cycle with `rec_ready` held high and results back-to-back.
- `ppu_ready_o` falls in the cycle after the DEPTH-th outstanding issue is captured. It rises in the cycle after the pop that leaves DEPTH−1 entries.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. Full/empty detection uses the wrap bit.

## Test plan

- SUB 120−0: `ppu_in1`=120, `ppu_in2`=0, `ppu_op`=SUB. The bench returns `ppu_out`=0x78 three cycles later. Required: one cycle later `rec_valid`=1 with seq=0, in1=120, op=SUB, in2=0, out=0x78; it pops with `rec_ready`=1.
- Back-to-back: SUB 120,0 then DIV 15,15, with results 0x78 and 0x4000 on consecutive cycles. Required: records seq 0 and seq 1 on consecutive cycles, in issue order.
- Backpressure (DEPTH=8): hold `rec_ready`=0, issue 8 operations and return 8 results.
  - Required: `ppu_ready_o`=0 and `outstanding`=8.
  - A 9th issue sets `err_overflow`=1 and is dropped.
  - Releasing `rec_ready` drains seq 0..7 in 8 cycles, with `ppu_ready_o`=1 after the first pop.
- Orphan: `ppu_valid_o`=1 after reset with nothing issued. Required: `err_orphan`=1, `rec_valid` stays 0, `outstanding`=0.
- Wrap: 20 issue/result/pop sequences with DEPTH=8. Required: seq 0..19 emitted in order, with no error flags set.
- Reset mid-operation: 3 outstanding entries, then `rst_n`=0 for one cycle. Required: all outputs reset immediately, and the next issue yields seq=0.
